// File: rtl/key_code_pkg.sv
// Shared constants and helpers for the key-code command queue.
package key_code_pkg;

  localparam int unsigned KEY_W     = 512;
  localparam int unsigned IDX_W     = 9;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned NUM_CODES = 13;

  // Main-row digit keys, index = {extend, scan}
  localparam logic [IDX_W-1:0] SC_0 = 9'h045;
  localparam logic [IDX_W-1:0] SC_1 = 9'h016;
  localparam logic [IDX_W-1:0] SC_2 = 9'h01E;
  localparam logic [IDX_W-1:0] SC_3 = 9'h026;
  localparam logic [IDX_W-1:0] SC_4 = 9'h025;
  localparam logic [IDX_W-1:0] SC_5 = 9'h02E;
  localparam logic [IDX_W-1:0] SC_6 = 9'h036;
  localparam logic [IDX_W-1:0] SC_7 = 9'h03D;
  localparam logic [IDX_W-1:0] SC_8 = 9'h03E;
  localparam logic [IDX_W-1:0] SC_9 = 9'h046;

  // Keypad digit keys
  localparam logic [IDX_W-1:0] KP_0 = 9'h070;
  localparam logic [IDX_W-1:0] KP_1 = 9'h069;
  localparam logic [IDX_W-1:0] KP_2 = 9'h072;
  localparam logic [IDX_W-1:0] KP_3 = 9'h07A;
  localparam logic [IDX_W-1:0] KP_4 = 9'h06B;
  localparam logic [IDX_W-1:0] KP_5 = 9'h073;
  localparam logic [IDX_W-1:0] KP_6 = 9'h074;
  localparam logic [IDX_W-1:0] KP_7 = 9'h06C;
  localparam logic [IDX_W-1:0] KP_8 = 9'h075;
  localparam logic [IDX_W-1:0] KP_9 = 9'h07D;

  // Control keys
  localparam logic [IDX_W-1:0] SC_ENTER    = 9'h05A;
  localparam logic [IDX_W-1:0] SC_KP_ENTER = 9'h15A;
  localparam logic [IDX_W-1:0] SC_BKSP     = 9'h066;
  localparam logic [IDX_W-1:0] SC_ESC      = 9'h076;

  localparam logic [CODE_W-1:0] CODE_ENTER = 4'hA;
  localparam logic [CODE_W-1:0] CODE_BKSP  = 4'hB;
  localparam logic [CODE_W-1:0] CODE_ESC   = 4'hC;

  // Per-command "some key for this command is down" vector
  function automatic logic [NUM_CODES-1:0] held_codes(input logic [KEY_W-1:0] kd);
    logic [NUM_CODES-1:0] v;
    v     = '0;
    v[0]  = kd[SC_0] | kd[KP_0];
    v[1]  = kd[SC_1] | kd[KP_1];
    v[2]  = kd[SC_2] | kd[KP_2];
    v[3]  = kd[SC_3] | kd[KP_3];
    v[4]  = kd[SC_4] | kd[KP_4];
    v[5]  = kd[SC_5] | kd[KP_5];
    v[6]  = kd[SC_6] | kd[KP_6];
    v[7]  = kd[SC_7] | kd[KP_7];
    v[8]  = kd[SC_8] | kd[KP_8];
    v[9]  = kd[SC_9] | kd[KP_9];
    v[CODE_ENTER] = kd[SC_ENTER] | kd[SC_KP_ENTER];
    v[CODE_BKSP]  = kd[SC_BKSP];
    v[CODE_ESC]   = kd[SC_ESC];
    return v;
  endfunction

  // Index of the lowest set bit (0 when none set)
  function automatic logic [CODE_W-1:0] lowest_code(input logic [NUM_CODES-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = NUM_CODES - 1; i >= 0; i--) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/key_code_fifo.sv
// Generic first-word-fall-through synchronous FIFO with wrap-bit pointers.
module key_code_fifo #(
  parameter int unsigned W      = 4,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [W-1:0]    i_data,
  input  logic            i_pop,
  input  logic            i_clear,
  output logic [W-1:0]    o_data,
  output logic            o_valid,
  output logic [ADDR_W:0] o_count,
  output logic            o_full
);

  logic [W-1:0]    r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] w_count;
  logic            w_full;
  logic            w_valid;
  logic            w_do_push;
  logic            w_do_pop;

  // Occupancy and accept decisions; a pop frees the slot a same-cycle push needs
  always_comb begin
    w_count   = r_wr_ptr - r_rd_ptr;
    w_full    = (w_count == (ADDR_W+1)'(DEPTH));
    w_valid   = (w_count != '0);
    w_do_pop  = i_pop & w_valid;
    w_do_push = i_push & (~w_full | i_pop);
  end

  // Pointer update; clear wins over push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  // Storage, zeroed on reset so the head reads 0 while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push && !i_clear) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
    end
  end

  assign o_data  = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_valid = w_valid;
  assign o_count = w_count;
  assign o_full  = w_full;

endmodule

// File: rtl/key_code_queue.sv
// Converts new presses of digit/Enter/Backspace/Esc into command codes and queues them.
module key_code_queue
  import key_code_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [511:0]     key_down,
  input  logic [8:0]       last_change,
  input  logic             key_valid,
  input  logic             pop,
  input  logic             clear,
  output logic [3:0]       code,
  output logic             code_valid,
  output logic [ADDR_W:0]  count,
  output logic             full,
  output logic             overflow
);

  logic [NUM_CODES-1:0] r_held_q;
  logic [NUM_CODES-1:0] w_held_now;
  logic [NUM_CODES-1:0] w_rise;
  logic                 w_push;
  logic                 w_multi;
  logic [CODE_W-1:0]    w_push_code;
  logic                 w_fifo_full;
  logic                 r_overflow;
  logic                 w_unused;

  // The key-down vector carries all needed state; last_change is informational only
  assign w_unused = ^{last_change, key_down};

  // Press detection and lowest-code selection
  always_comb begin
    w_held_now  = held_codes(key_down);
    w_rise      = key_valid ? (w_held_now & ~r_held_q) : '0;
    w_push      = |w_rise;
    w_multi     = |(w_rise & (w_rise - NUM_CODES'(1)));
    w_push_code = lowest_code(w_rise);
  end

  // Previous held vector, tracked every cycle (including during clear)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_held_q <= '0;
    else     r_held_q <= w_held_now;
  end

  // Sticky overflow: simultaneous presses, or a push into a full FIFO with no pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_multi || (w_push && w_fifo_full && !pop)) begin
      r_overflow <= 1'b1;
    end
  end

  key_code_fifo #(
    .W      (CODE_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_code),
    .i_pop   (pop),
    .i_clear (clear),
    .o_data  (code),
    .o_valid (code_valid),
    .o_count (count),
    .o_full  (w_fifo_full)
  );

  assign full     = w_fifo_full;
  assign overflow = r_overflow;

endmodule
